// File: rtl/mm_pkg.sv
// Shared types and constants for the Mastermind round sequencer and its datapath.
package mm_pkg;

  localparam int unsigned NUM_PEGS = 4;
  localparam int unsigned PEG_W    = 3;
  localparam int unsigned SCORE_W  = 3;
  localparam int unsigned WIN_RED  = 4;
  localparam int unsigned SLOT_W   = $clog2(NUM_PEGS);

  typedef enum logic [3:0] {
    CODE_ENTRY,
    CODE_ACCEPT,
    CODE_WAIT,
    GUESS_ENTRY,
    GUESS_ACCEPT,
    GUESS_WAIT,
    CLEAR,
    SCORE,
    SETTLE,
    JUDGE,
    WIN,
    LOSE
  } state_t;

  // Key handshake phase seen by the press tracker.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ENTRY,
    PH_ACCEPT,
    PH_WAIT
  } phase_t;

endpackage

// File: rtl/mm_round_sequencer_if.sv
// Key input, slot strobes and compare-datapath controls between sequencer and board.
interface mm_round_sequencer_if
  import mm_pkg::*;
();

  logic               load;
  logic [SCORE_W-1:0] red_in;
  logic [SCORE_W-1:0] white_in;
  logic               load_code_en;
  logic               load_guess_en;
  logic [SLOT_W-1:0]  slot;
  logic               clear_score;
  logic               compare_en;
  logic [SLOT_W-1:0]  compare_i;

  modport master (
    input  load, red_in, white_in,
    output load_code_en, load_guess_en, slot, clear_score, compare_en, compare_i
  );

  modport slave (
    output load, red_in, white_in,
    input  load_code_en, load_guess_en, slot, clear_score, compare_en, compare_i
  );

endinterface

// File: rtl/mm_press_tracker.sv
// Press/release detector for the ENTRY/ACCEPT/WAIT key handshake.
module mm_press_tracker
  import mm_pkg::*;
(
  input  phase_t phase,
  input  logic   load,
  output logic   accept,
  output logic   released
);

  always_comb begin
    accept   = (phase == PH_ENTRY) && load;
    released = (phase == PH_WAIT) && !load;
  end

endmodule

// File: rtl/mm_round_sequencer.sv
// Game sequencer: code/guess slot entry, clear/compare/settle scoring, judging, win/lose.
module mm_round_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned MAX_GUESSES = 8
) (
  input  logic               clock,
  input  logic               reset,
  mm_round_sequencer_if.master bus,
  output logic [SCORE_W-1:0] last_red,
  output logic [SCORE_W-1:0] last_white,
  output logic [3:0]         guess_count,
  output logic               win,
  output logic               lose,
  output logic               busy
);

  state_t             state, state_d;
  phase_t             phase;
  logic [SLOT_W-1:0]  slot, slot_d;
  logic [SLOT_W-1:0]  idx, idx_d;
  logic [3:0]         gc_d, gc_inc;
  logic [SCORE_W-1:0] red_d, white_d;
  logic               end_armed, armed_d;
  logic               accept, released;

  // WIN/LOSE reuse the tracker: unarmed waits for a press, armed waits for release.
  always_comb begin
    phase = PH_IDLE;
    unique case (state)
      CODE_ENTRY, GUESS_ENTRY:   phase = PH_ENTRY;
      CODE_ACCEPT, GUESS_ACCEPT: phase = PH_ACCEPT;
      CODE_WAIT, GUESS_WAIT:     phase = PH_WAIT;
      WIN, LOSE:                 phase = end_armed ? PH_WAIT : PH_ENTRY;
      default:                   phase = PH_IDLE;
    endcase
  end

  mm_press_tracker u_press (
    .phase    (phase),
    .load     (bus.load),
    .accept   (accept),
    .released (released)
  );

  always_comb begin
    state_d = state;
    slot_d  = slot;
    idx_d   = idx;
    gc_d    = guess_count;
    red_d   = last_red;
    white_d = last_white;
    armed_d = end_armed;
    gc_inc  = (guess_count == 4'hF) ? 4'hF : guess_count + 4'd1;
    unique case (state)
      CODE_ENTRY:  if (accept) state_d = CODE_ACCEPT;
      CODE_ACCEPT: state_d = CODE_WAIT;
      CODE_WAIT: begin
        if (released) begin
          if (slot == SLOT_W'(NUM_PEGS - 1)) begin
            state_d = GUESS_ENTRY;
            slot_d  = '0;
          end else begin
            state_d = CODE_ENTRY;
            slot_d  = slot + 1'b1;
          end
        end
      end
      GUESS_ENTRY:  if (accept) state_d = GUESS_ACCEPT;
      GUESS_ACCEPT: state_d = GUESS_WAIT;
      GUESS_WAIT: begin
        if (released) begin
          if (slot == SLOT_W'(NUM_PEGS - 1)) begin
            state_d = CLEAR;
            slot_d  = '0;
          end else begin
            state_d = GUESS_ENTRY;
            slot_d  = slot + 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = SCORE;
        idx_d   = '0;
      end
      SCORE: begin
        idx_d = idx + 1'b1;
        if (idx == SLOT_W'(NUM_PEGS - 1)) state_d = SETTLE;
      end
      SETTLE: state_d = JUDGE;
      JUDGE: begin
        red_d   = bus.red_in;
        white_d = bus.white_in;
        gc_d    = gc_inc;
        if (bus.red_in == SCORE_W'(WIN_RED))  state_d = WIN;
        else if (gc_inc == 4'(MAX_GUESSES))   state_d = LOSE;
        else begin
          state_d = GUESS_ENTRY;
          slot_d  = '0;
        end
      end
      WIN, LOSE: begin
        if (accept) armed_d = 1'b1;
        if (released) begin
          state_d = CODE_ENTRY;
          armed_d = 1'b0;
          slot_d  = '0;
          gc_d    = '0;
          red_d   = '0;
          white_d = '0;
        end
      end
      default: state_d = CODE_ENTRY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= CODE_ENTRY;
      slot        <= '0;
      idx         <= '0;
      guess_count <= '0;
      last_red    <= '0;
      last_white  <= '0;
      end_armed   <= 1'b0;
    end else begin
      state       <= state_d;
      slot        <= slot_d;
      idx         <= idx_d;
      guess_count <= gc_d;
      last_red    <= red_d;
      last_white  <= white_d;
      end_armed   <= armed_d;
    end
  end

  always_comb begin
    bus.load_code_en  = (state == CODE_ACCEPT);
    bus.load_guess_en = (state == GUESS_ACCEPT);
    bus.slot          = slot;
    bus.clear_score   = (state == CLEAR);
    bus.compare_en    = (state == SCORE);
    bus.compare_i     = (state == SCORE) ? idx : '0;
    win               = (state == WIN);
    lose              = (state == LOSE);
    busy              = (state == CLEAR) || (state == SCORE) ||
                        (state == SETTLE) || (state == JUDGE);
  end

endmodule

// File: doc/mm_round_sequencer.md
# mm_round_sequencer

Round and game sequencer for the Mastermind board. It takes debounced key presses and issues the slot load strobes for the secret code and each guess. It runs the clear / four-compare / settle scoring sequence on the compare datapath, then judges each guess from the returned red and white counts. It counts attempts and ends the game with win or lose. Once a game ends, the next press starts a new game.

## Interface
Parameters:
- MAX_GUESSES, default 8: number of guesses allowed per game (1..15).

Ports:
- clock  in  1: single system clock.
- reset  in  1: asynchronous, active-high reset.
- load  in  1: level input, high while the key is held; already debounced and synchronous to clock.
- red_in  in  3: red count returned by the compare datapath.
- white_in  in  3: white count returned by the compare datapath.
- load_code_en  out  1: one-cycle strobe; the datapath writes data_in into code slot `slot`.
- load_guess_en  out  1: one-cycle strobe; the datapath writes data_in into guess slot `slot`.
- slot  out  2: slot index (0..3) for the strobes.
- clear_score  out  1: clears the datapath red/white/matched registers.
- compare_en  out  1: enables the compare step.
- compare_i  out  2: code index being compared.
- last_red  out  3: red count of the last judged guess.
- last_white  out  3: white count of the last judged guess.
- guess_count  out  4: number of guesses judged in this game.
- win  out  1: level; high while in WIN.
- lose  out  1: level; high while in LOSE.
- busy  out  1: high during scoring (CLEAR through JUDGE).

## Operation
- States: CODE_ENTRY, CODE_ACCEPT, CODE_WAIT, GUESS_ENTRY, GUESS_ACCEPT, GUESS_WAIT, CLEAR, SCORE, SETTLE, JUDGE, WIN, LOSE.
- A 2-bit slot register indexes both entry phases. A 2-bit index register drives compare_i during scoring.
- All outputs are decoded from registered state only (Moore outputs).
- Code entry:
  - *_ENTRY with load=1 goes to *_ACCEPT.
  - *_ACCEPT lasts one cycle and asserts load_code_en, then goes to *_WAIT.
  - *_WAIT holds until load=0, then increments slot.
  - After slot 3 is released, go to GUESS_ENTRY with slot=0.
- Guess entry uses the same ENTRY/ACCEPT/WAIT pattern with load_guess_en. After slot 3 is released, go to CLEAR.
- CLEAR (1 cycle): clear_score=1.
- SCORE (4 cycles): compare_en=1, compare_i = 0,1,2,3 in order.
- SETTLE (1 cycle): all controls idle, letting the score registers update.
- JUDGE (1 cycle):
  - Latch red_in into last_red and white_in into last_white.
  - Increment guess_count; it saturates at 15.
  - If red_in == 4, go to WIN.
  - Else if the incremented count == MAX_GUESSES, go to LOSE.
  - Else go to GUESS_ENTRY with slot=0.
- WIN/LOSE:
  - Hold until a press-release on load.
  - Then go to CODE_ENTRY, clearing slot, guess_count, last_red and last_white.
  - The clear happens on the transition.
- load is ignored in CLEAR, SCORE, SETTLE and JUDGE. If load is still high on return to GUESS_ENTRY, the next ACCEPT follows immediately; a held key is not re-armed.
- red_in values above 4 are treated as not-win.

## Timing
- Reset (asynchronous):
  - State goes to CODE_ENTRY.
  - slot, index, guess_count, last_red and last_white go to 0.
  - Every strobe, win, lose and busy go to 0.
- Reset mid-scoring or mid-entry aborts immediately. No partial judge is recorded.
- Strobe latency: one cycle after load is sampled high. data_in must be stable in the ACCEPT cycle.
- Scoring latency, with release of guess slot 3 sampled at cycle t:
  - CLEAR at t+1.
  - SCORE at t+2..t+5.
  - SETTLE at t+6.
  - JUDGE at t+7.
  - last_red/last_white valid and win/lose asserted at t+8.
- busy is high in cycles t+1..t+7.
- Never asserted together:
  - load_code_en and load_guess_en.
  - compare_en and clear_score.
  - win and lose.

## Structure
- The shared package mm_pkg holds:
  - the state enum,
  - NUM_PEGS=4,
  - PEG_W=3,
  - SCORE_W=3,
  - WIN_RED=4.
- One natural sub-module, mm_press_tracker: the ENTRY/ACCEPT/WAIT handshake. It takes load and gives an accept pulse and a release pulse, and is instantiated once. Slot sequencing and scoring stay in the top module.

## Test plan
- Reset then enter code 5,1,3,7:
  - Four load_code_en pulses, each 1 cycle, with slot = 0,1,2,3.
  - State ends in GUESS_ENTRY with guess_count=0.
- Exact guess 5,1,3,7 with red_in driven to 4 at JUDGE:
  - CLEAR lasts 1 cycle; compare_i runs 0..3; JUDGE at release+7.
  - win=1, last_red=4, guess_count=1.
- With MAX_GUESSES=2, two guesses with red_in=1, white_in=2:
  - After the first guess, back in GUESS_ENTRY with last_white=2.
  - After the second, lose=1 and guess_count=2.
- Load held across the whole scoring window:
  - No strobe during busy.
  - A single load_guess_en for slot 0 follows immediately after JUDGE.
  - No second strobe until release and a new press.
- Reset asserted during SCORE with compare_i=2:
  - compare_en drops asynchronously.
  - State is CODE_ENTRY and guess_count=0.
- From WIN, press and release:
  - Returns to CODE_ENTRY with last_red=0, last_white=0, win=0.
